// File: rtl/ex_mem_stage_buf.sv
// rtl/ex_mem_stage_buf.sv - EX->MEM pipeline stage with valid/ready handshake, flush and optional skid entry
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   flush               drops every held entry (and any input accepted this cycle)
//   in_valid/in_ready   EX-side handshake; in_* carries alu result, store data, rd, ctrl
//   out_valid/out_ready MEM-side handshake; out_* presents the oldest held entry
//   out_ctrl            masked to zero whenever out_valid is low
module ex_mem_stage_buf #(
    parameter int DATA_W = 32,
    parameter int RD_W   = 5,
    parameter int CTRL_W = 4,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic [DATA_W-1:0] in_write_data,
    input  logic [RD_W-1:0]   in_rd,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_alu_result,
    output logic [DATA_W-1:0] out_write_data,
    output logic [RD_W-1:0]   out_rd,
    output logic [CTRL_W-1:0] out_ctrl
);

    logic              main_valid;
    logic [DATA_W-1:0] main_alu;
    logic [DATA_W-1:0] main_wd;
    logic [RD_W-1:0]   main_rd;
    logic [CTRL_W-1:0] main_ctrl;

    logic              skid_valid;
    logic [DATA_W-1:0] skid_alu;
    logic [DATA_W-1:0] skid_wd;
    logic [RD_W-1:0]   skid_rd;
    logic [CTRL_W-1:0] skid_ctrl;

    logic accept;
    logic consume;
    logic load_main;

    assign accept    = in_valid & in_ready;
    assign consume   = main_valid & out_ready;
    // Main entry is free to take new contents when empty or being drained this cycle.
    assign load_main = ~main_valid | consume;

    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid <= 1'b0;
            main_alu   <= '0;
            main_wd    <= '0;
            main_rd    <= '0;
            main_ctrl  <= '0;
        end else if (flush) begin
            main_valid <= 1'b0;
        end else if (load_main) begin
            // Skid entry is older than anything on the input, so it goes first.
            main_valid <= skid_valid | accept;
            if (skid_valid) begin
                main_alu  <= skid_alu;
                main_wd   <= skid_wd;
                main_rd   <= skid_rd;
                main_ctrl <= skid_ctrl;
            end else if (accept) begin
                main_alu  <= in_alu_result;
                main_wd   <= in_write_data;
                main_rd   <= in_rd;
                main_ctrl <= in_ctrl;
            end
        end
    end

    generate
        if (SKID != 0) begin : g_skid
            // Ready depends only on registered state, breaking the out_ready -> in_ready path.
            assign in_ready = ~rst & ~skid_valid;

            always_ff @(posedge clk) begin
                if (rst) begin
                    skid_valid <= 1'b0;
                    skid_alu   <= '0;
                    skid_wd    <= '0;
                    skid_rd    <= '0;
                    skid_ctrl  <= '0;
                end else if (flush) begin
                    skid_valid <= 1'b0;
                end else if (skid_valid) begin
                    // No accept is possible while full, so draining simply empties it.
                    if (load_main) begin
                        skid_valid <= 1'b0;
                    end
                end else if (accept && !load_main) begin
                    skid_valid <= 1'b1;
                    skid_alu   <= in_alu_result;
                    skid_wd    <= in_write_data;
                    skid_rd    <= in_rd;
                    skid_ctrl  <= in_ctrl;
                end
            end
        end else begin : g_noskid
            assign in_ready   = ~rst & load_main;
            assign skid_valid = 1'b0;
            assign skid_alu   = '0;
            assign skid_wd    = '0;
            assign skid_rd    = '0;
            assign skid_ctrl  = '0;
        end
    endgenerate

    assign out_valid      = main_valid;
    assign out_alu_result = main_alu;
    assign out_write_data = main_wd;
    assign out_rd         = main_rd;
    // Bubbles must never look like a register or memory write downstream.
    assign out_ctrl       = main_ctrl & {CTRL_W{main_valid}};

endmodule

// File: tb/tb_ex_mem_stage_buf.sv
// tb/tb_ex_mem_stage_buf.sv - self-checking bench for ex_mem_stage_buf, SKID=1 and SKID=0 instances
module tb_ex_mem_stage_buf;

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] wd;
        logic [4:0]  rd;
        logic [3:0]  ctrl;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_alu;
    logic [31:0] in_wd;
    logic [4:0]  in_rd;
    logic [3:0]  in_ctrl;
    logic        out_ready;

    logic        in_ready1, out_valid1;
    logic [31:0] out_alu1, out_wd1;
    logic [4:0]  out_rd1;
    logic [3:0]  out_ctrl1;

    logic        in_ready0, out_valid0;
    logic [31:0] out_alu0, out_wd0;
    logic [4:0]  out_rd0;
    logic [3:0]  out_ctrl0;

    int pass_cnt  = 0;
    int total_cnt = 0;
    bit chk_en    = 1'b0;

    ent_t q1[$];
    ent_t q0[$];

    always #5 clk = ~clk;

    ex_mem_stage_buf #(.DATA_W(32), .RD_W(5), .CTRL_W(4), .SKID(1)) dut1 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready1),
        .in_alu_result(in_alu), .in_write_data(in_wd), .in_rd(in_rd), .in_ctrl(in_ctrl),
        .out_valid(out_valid1), .out_ready(out_ready),
        .out_alu_result(out_alu1), .out_write_data(out_wd1), .out_rd(out_rd1), .out_ctrl(out_ctrl1)
    );

    ex_mem_stage_buf #(.DATA_W(32), .RD_W(5), .CTRL_W(4), .SKID(0)) dut0 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready0),
        .in_alu_result(in_alu), .in_write_data(in_wd), .in_rd(in_rd), .in_ctrl(in_ctrl),
        .out_valid(out_valid0), .out_ready(out_ready),
        .out_alu_result(out_alu0), .out_write_data(out_wd0), .out_rd(out_rd0), .out_ctrl(out_ctrl0)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Model: a FIFO of capacity 2 (skid) or 1 (no skid).
    function automatic bit model_ready(input int size, input bit skid);
        if (rst) return 1'b0;
        if (skid) return size < 2;
        return (size == 0) || out_ready;
    endfunction

    ent_t cur;
    bit   acc1, acc0, con1, con0;

    always @(posedge clk) begin
        cur  = '{alu: in_alu, wd: in_wd, rd: in_rd, ctrl: in_ctrl};
        acc1 = in_valid && model_ready(q1.size(), 1'b1);
        acc0 = in_valid && model_ready(q0.size(), 1'b0);
        con1 = (q1.size() > 0) && out_ready;
        con0 = (q0.size() > 0) && out_ready;
        if (rst || flush) begin
            q1.delete();
            q0.delete();
        end else begin
            if (con1) void'(q1.pop_front());
            if (acc1) q1.push_back(cur);
            if (con0) void'(q0.pop_front());
            if (acc0) q0.push_back(cur);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("s1_in_ready", {63'd0, in_ready1}, {63'd0, model_ready(q1.size(), 1'b1)});
            check("s1_out_valid", {63'd0, out_valid1}, {63'd0, q1.size() > 0});
            check("s1_out_ctrl", {60'd0, out_ctrl1}, {60'd0, (q1.size() > 0) ? q1[0].ctrl : 4'd0});
            if (q1.size() > 0) begin
                check("s1_payload", {out_alu1, out_wd1}, {q1[0].alu, q1[0].wd});
                check("s1_rd", {59'd0, out_rd1}, {59'd0, q1[0].rd});
            end
            check("s0_in_ready", {63'd0, in_ready0}, {63'd0, model_ready(q0.size(), 1'b0)});
            check("s0_out_valid", {63'd0, out_valid0}, {63'd0, q0.size() > 0});
            check("s0_out_ctrl", {60'd0, out_ctrl0}, {60'd0, (q0.size() > 0) ? q0[0].ctrl : 4'd0});
            if (q0.size() > 0) begin
                check("s0_payload", {out_alu0, out_wd0}, {q0[0].alu, q0[0].wd});
                check("s0_rd", {59'd0, out_rd0}, {59'd0, q0[0].rd});
            end
        end
    end

    task automatic set_in(input bit v, input logic [31:0] alu, input logic [3:0] ctrl,
                          input bit ordy, input bit fl);
        in_valid  = v;
        in_alu    = alu;
        in_wd     = alu ^ 32'hA5A5_0000;
        in_rd     = alu[4:0];
        in_ctrl   = ctrl;
        out_ready = ordy;
        flush     = fl;
    endtask

    task automatic drive(input bit v, input logic [31:0] alu, input logic [3:0] ctrl,
                         input bit ordy, input bit fl);
        set_in(v, alu, ctrl, ordy, fl);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        set_in(1'b0, 32'd0, 4'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        @(posedge clk);
        #1;
        // Reset state
        check("rst_out_valid", {63'd0, out_valid1}, 64'd0);
        check("rst_out_alu", {32'd0, out_alu1}, 64'd0);
        check("rst_out_ctrl", {60'd0, out_ctrl1}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready1}, 64'd0);
        rst = 1'b0;

        // 1. Stream: one-cycle latency, one result per cycle
        for (int i = 1; i <= 5; i++) begin
            drive(1'b1, i, 4'b0001, 1'b1, 1'b0);
            check("stream_s1", {32'd0, out_alu1}, i);
            check("stream_s0", {32'd0, out_alu0}, i);
        end

        // 4. Bubble with all ctrl bits set on the input
        drive(1'b0, 32'hDEAD, 4'b1111, 1'b1, 1'b0);
        check("bubble_valid", {63'd0, out_valid1}, 64'd0);
        check("bubble_ctrl", {60'd0, out_ctrl1}, 64'd0);
        check("bubble_ctrl_s0", {60'd0, out_ctrl0}, 64'd0);

        // 2. Stall with A, B, C offered, then release
        drive(1'b1, 32'h10, 4'b0011, 1'b0, 1'b0);
        check("stall_A", {32'd0, out_alu1}, 64'h10);
        drive(1'b1, 32'h11, 4'b0101, 1'b0, 1'b0);
        check("stall_A_hold", {32'd0, out_alu1}, 64'h10);
        drive(1'b1, 32'h12, 4'b1001, 1'b0, 1'b0);
        check("stall_full_ready", {63'd0, in_ready1}, 64'd0);
        check("stall_A_hold2", {32'd0, out_alu1}, 64'h10);
        drive(1'b1, 32'h12, 4'b1001, 1'b1, 1'b0);
        check("release_B", {32'd0, out_alu1}, 64'h11);
        drive(1'b1, 32'h12, 4'b1001, 1'b1, 1'b0);
        check("release_C", {32'd0, out_alu1}, 64'h12);
        drive(1'b0, 32'h0, 4'b0000, 1'b1, 1'b0);
        check("drained", {63'd0, out_valid1}, 64'd0);

        // 3. Flush with two entries held, C offered
        drive(1'b1, 32'h20, 4'b0001, 1'b0, 1'b0);
        drive(1'b1, 32'h21, 4'b0001, 1'b0, 1'b0);
        drive(1'b1, 32'h22, 4'b0001, 1'b0, 1'b1);
        check("flush_valid", {63'd0, out_valid1}, 64'd0);
        check("flush_ctrl", {60'd0, out_ctrl1}, 64'd0);
        drive(1'b0, 32'h0, 4'b0000, 1'b1, 1'b0);
        check("flush_no_C", {63'd0, out_valid1}, 64'd0);
        // Flush while an input is actually accepted: it must be discarded
        drive(1'b1, 32'h23, 4'b0001, 1'b0, 1'b0);
        drive(1'b1, 32'h24, 4'b0001, 1'b0, 1'b1);
        check("flush_acc_valid", {63'd0, out_valid1}, 64'd0);
        drive(1'b0, 32'h0, 4'b0000, 1'b1, 1'b0);
        check("flush_acc_gone", {63'd0, out_valid1}, 64'd0);

        // 5. SKID=0 combinational ready
        drive(1'b1, 32'h30, 4'b0001, 1'b0, 1'b0);
        check("s0_hold_A", {32'd0, out_alu0}, 64'h30);
        set_in(1'b1, 32'h31, 4'b0001, 1'b0, 1'b0);
        #1;
        check("s0_ready_low", {63'd0, in_ready0}, 64'd0);
        out_ready = 1'b1;
        #1;
        check("s0_ready_high", {63'd0, in_ready0}, 64'd1);
        @(posedge clk);
        #1;
        check("s0_out_B", {32'd0, out_alu0}, 64'h31);
        check("s1_out_B", {32'd0, out_alu1}, 64'h31);
        drive(1'b0, 32'h0, 4'b0000, 1'b1, 1'b0);

        // 6. Reset with two entries held
        drive(1'b1, 32'h40, 4'b0111, 1'b0, 1'b0);
        drive(1'b1, 32'h41, 4'b0111, 1'b0, 1'b0);
        set_in(1'b0, 32'h0, 4'b0000, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        check("rst_mid_ready", {63'd0, in_ready1}, 64'd0);
        @(posedge clk);
        #1;
        check("rst_mid_valid", {63'd0, out_valid1}, 64'd0);
        check("rst_mid_data", {out_alu1, out_wd1}, 64'd0);
        check("rst_mid_rd", {59'd0, out_rd1}, 64'd0);
        check("rst_mid_ctrl", {60'd0, out_ctrl1}, 64'd0);
        rst = 1'b0;
        #1;
        check("rst_after_ready", {63'd0, in_ready1}, 64'd1);
        @(posedge clk);
        #1;

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
